// File: rtl/ram2_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and data ports through a five-state access FSM.
// Optional macro RAM2_FAIR_EN: after a data-port completion, a pending fetch wins the next grant once.
module ram2_arbiter #(
    parameter int SRAM_ADDR_W = 20,
    parameter int READ_WAIT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [31:0]            if_addr_i,
    output logic [31:0]            if_inst_o,
    output logic                   if_ack_o,
    input  logic                   mem_ce_i,
    input  logic                   mem_re_i,
    input  logic                   mem_we_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [31:0]            mem_data_i,
    output logic [31:0]            mem_data_o,
    output logic                   mem_ack_o,
    output logic                   stallreq_o,
    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    output logic [31:0]            sram_data_o,
    input  logic [31:0]            sram_data_i,
    output logic                   sram_drive_o,
    output logic                   sram_ce_n_o,
    output logic                   sram_oe_n_o,
    output logic                   sram_we_n_o
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, DONE} state_t;

    state_t                 r_state, w_next;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_if_inst;
    logic [31:0]            r_mem_data;
    logic                   r_owner_mem;
    logic                   r_is_write;
    logic [2:0]             r_wait_cnt;
    logic                   w_mem_req;
    logic                   w_if_first;
    logic                   w_grant_mem;
    logic                   w_grant_if;
    logic                   w_ce_n, w_oe_n, w_we_n, w_drive;
    logic                   w_unused;

    // Address bits above the SRAM width alias silently.
    assign w_unused  = ^{if_addr_i, mem_addr_i};
    assign w_mem_req = mem_ce_i & (mem_re_i | mem_we_i);

`ifdef RAM2_FAIR_EN
    logic r_fair;

    always_ff @(posedge clk) begin
        if (rst)
            r_fair <= 1'b0;
        else if (w_grant_if)
            r_fair <= 1'b0;
        else if (r_state == DONE && r_owner_mem)
            r_fair <= 1'b1;
    end

    assign w_if_first = r_fair & if_req_i;
`else
    assign w_if_first = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        w_ce_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_drive     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_first)
                    w_grant_if = 1'b1;
                else if (w_mem_req)
                    w_grant_mem = 1'b1;
                else if (if_req_i)
                    w_grant_if = 1'b1;
                if (w_grant_mem && mem_we_i)
                    w_next = WR_SETUP;
                else if (w_grant_mem || w_grant_if)
                    w_next = RD;
            end
            RD: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
                if (r_wait_cnt == 3'd0)
                    w_next = DONE;
            end
            WR_SETUP: begin
                w_ce_n  = 1'b0;
                w_drive = 1'b1;
                w_next  = WR_PULSE;
            end
            WR_PULSE: begin
                w_ce_n  = 1'b0;
                w_we_n  = 1'b0;
                w_drive = 1'b1;
                w_next  = DONE;
            end
            DONE: begin
                // Keep driving write data one cycle past the rising we_n edge.
                w_drive = r_is_write;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_inst   <= '0;
            r_mem_data  <= '0;
            r_owner_mem <= 1'b0;
            r_is_write  <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_grant_mem || w_grant_if) begin
                r_addr      <= w_grant_mem ? mem_addr_i[SRAM_ADDR_W-1:0] : if_addr_i[SRAM_ADDR_W-1:0];
                r_wdata     <= w_grant_mem ? mem_data_i : r_wdata;
                r_owner_mem <= w_grant_mem;
                r_is_write  <= w_grant_mem & mem_we_i;
                r_wait_cnt  <= 3'(READ_WAIT);
            end
            if (r_state == RD) begin
                if (r_wait_cnt != 3'd0)
                    r_wait_cnt <= r_wait_cnt - 3'd1;
                else if (r_owner_mem)
                    r_mem_data <= sram_data_i;
                else
                    r_if_inst <= sram_data_i;
            end
        end
    end

    assign if_ack_o     = (r_state == DONE) & ~r_owner_mem;
    assign mem_ack_o    = (r_state == DONE) & r_owner_mem;
    assign if_inst_o    = r_if_inst;
    assign mem_data_o   = r_mem_data;
    assign stallreq_o   = (w_mem_req & ~mem_ack_o) | (if_req_i & ~if_ack_o);
    assign sram_addr_o  = r_addr;
    assign sram_data_o  = r_wdata;
    assign sram_drive_o = w_drive;
    assign sram_ce_n_o  = w_ce_n;
    assign sram_oe_n_o  = w_oe_n;
    assign sram_we_n_o  = w_we_n;

endmodule
